medida_uart_tx: RTL
===================

# medida_uart_tx

Serializes one DHT11 measurement as a fixed 13-byte ASCII frame on the UART line. It sits directly downstream of the DHT11 interface and the datapath measurement registers, and is driven by the controller's `transmite_medida` pulse. It returns a `pronto` pulse when the frame is complete. The frame format is `T<tt>.<t> U<uu>.<u>` followed by CR LF.

## Interface
- `BAUD_DIV`, default 434: clock cycles per UART bit (50 MHz / 115200).
- `clock` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. Forces the reset values below.
- `transmite` input 1: start request, level-sampled only in OCIOSO. Upstream supplies a 1-cycle pulse.
- `temperatura` input 16: [15:8] integer °C, [7:0] decimal tenths.
- `umidade` input 16: [15:8] integer %RH, [7:0] decimal tenths.
- `tx_serial` output 1: UART 8N1, LSB first, idle high.
- `ocupado` output 1: high from CARREGA through FIM.
- `pronto` output 1: 1-cycle pulse at frame end.
- `db_estado` output 3: main FSM state code.

## Operation
- **Frame:** 13 bytes, sent in index order 0..12:
  - 0: 'T' (0x54)
  - 1–2: temperature tens, units
  - 3: '.' (0x2E)
  - 4: temperature tenth
  - 5: ' ' (0x20)
  - 6: 'U' (0x55)
  - 7–8: humidity tens, units
  - 9: '.'
  - 10: humidity tenth
  - 11: CR (0x0D)
  - 12: LF (0x0A)
- **Digit encoding:** each digit is 0x30 + value.
- **Integer clamp:** an integer byte above 99 is encoded as 99.
- **Decimal clamp:** a decimal byte above 9 is encoded as 9.
- **Digit source:** digits are computed from latched copies of the inputs, never from live inputs.
- **Main FSM states (`db_estado` code in parentheses):**
  - OCIOSO (0): `tx_serial`=1. If `transmite`=1 → CARREGA.
  - CARREGA (1): latch `temperatura` and `umidade`, clear byte index → ENVIA.
  - ENVIA (2): load byte[index] into the shifter, start the serializer → ESPERA.
  - ESPERA (3): wait for the serializer to finish the stop bit. If index=12 → FIM, else → PROXIMO.
  - PROXIMO (4): index+1 → ENVIA.
  - FIM (5): `pronto`=1 for this cycle → OCIOSO.
- **Serializer:** shifts out 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1). Each bit is held exactly `BAUD_DIV` cycles by a bit-period counter (width ≥ clog2(`BAUD_DIV`)). A 4-bit counter tracks bit position.
- **Busy behaviour:** `transmite` is ignored outside OCIOSO. Input changes after CARREGA do not affect the frame in progress.
- **Held-high request:** if `transmite` is still high on return to OCIOSO, a new frame starts. This is legal; it is upstream's job to pulse.
- **Reset values:** `tx_serial`=1, `ocupado`=0, `pronto`=0, `db_estado`=0, index=0, all counters 0.
- **Reset mid-frame:** the line returns high immediately. No partial byte resumes after reset release.

## Timing
- **Start latency:** `transmite` sampled high at edge k → CARREGA at k, ENVIA at k+1, `tx_serial` falls at edge k+2.
- **Byte duration:** 10×`BAUD_DIV` cycles on the line.
- **Inter-byte gap:** exactly 2 idle-high cycles between a stop bit ending and the next start bit (PROXIMO, ENVIA).
- **Frame end:** `pronto` is high the cycle after the byte-12 stop bit completes. `ocupado` drops together with `pronto`.
- **Total:** 2 + 13×10×`BAUD_DIV` + 12×2 + 1 cycles from the `transmite` sample to `ocupado` low.
- **Earliest restart:** a new `transmite` is accepted on the first OCIOSO cycle after FIM.

## Test plan
All scenarios run with `BAUD_DIV`=4.
- **Nominal frame:** `temperatura`=16'h1903, `umidade`=16'h3C00, 1-cycle `transmite` → UART decodes 54 32 35 2E 33 20 55 36 30 2E 30 0D 0A. One `pronto` pulse; 2+520+24+1 cycles total.
- **Clamp:** `temperatura`=16'h780F (120, 15), `umidade`=16'h0005 → digit bytes 39 39 / 39 and 30 30 / 35.
- **Input change and re-request while busy:** change the inputs and pulse `transmite` during byte 4 → frame uses the latched values, no second frame, a single `pronto`.
- **Reset mid-frame:** assert `reset`=0 during byte 7's data bits → `tx_serial`=1, `ocupado`=0, `db_estado`=0 immediately. After release, a fresh `transmite` sends a complete frame from byte 0.
- **Held-high `transmite`:** hold `transmite` high for 2 frames → the second start bit begins 2 cycles after the OCIOSO cycle following the first `pronto`.
- **Bit timing:** measure every bit width = 4 cycles and every inter-byte idle gap = 2 cycles. Verify `db_estado` walks 0→1→2→3→4→2…→3→5→0.

Source files
------------

// File: rtl/medida_uart_tx.sv
// medida_uart_tx: sends one DHT11 measurement as a 13-byte ASCII frame
// "T<tt>.<t> U<uu>.<u>\r\n" over a UART 8N1 line, LSB first.
// Digits come from copies of the inputs taken in CARREGA.
// Changes on the live inputs after that point cannot disturb a frame
// that is already being sent.

module medida_uart_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        transmite,
  input  logic [15:0] temperatura,
  input  logic [15:0] umidade,
  output logic        tx_serial,
  output logic        ocupado,
  output logic        pronto,
  output logic [2:0]  db_estado
);

  localparam int            CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ENVIA   = 3'd2,
    ESPERA  = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [3:0]    idx_q, idx_d;
  logic [15:0]   temp_q, temp_d;
  logic [15:0]   umid_q, umid_d;
  logic          ser_start;

  // serializer state
  logic          ativo_q, ativo_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          ser_fim;
  logic [7:0]    byte_atual;
  logic [15:0]   temp_int_asc, umid_int_asc;
  logic [7:0]    temp_dec_asc, umid_dec_asc;

  // Integer part -> two ASCII digits (tens, units), saturated at 99
  function automatic logic [15:0] int_ascii(input logic [7:0] v);
    logic [6:0] s, t, u;
    s = (v > 8'd99) ? 7'd99 : v[6:0];
    t = s / 7'd10;
    u = s % 7'd10;
    return {8'h30 | {1'b0, t}, 8'h30 | {1'b0, u}};
  endfunction

  // Tenths -> one ASCII digit, saturated at 9
  function automatic logic [7:0] dec_ascii(input logic [7:0] v);
    return (v > 8'd9) ? 8'h39 : (8'h30 | v);
  endfunction

  assign temp_int_asc = int_ascii(temp_q[15:8]);
  assign umid_int_asc = int_ascii(umid_q[15:8]);
  assign temp_dec_asc = dec_ascii(temp_q[7:0]);
  assign umid_dec_asc = dec_ascii(umid_q[7:0]);

  // Frame byte selected by the current index
  always_comb begin
    byte_atual = 8'h0A;
    case (idx_q)
      4'd0:    byte_atual = 8'h54;
      4'd1:    byte_atual = temp_int_asc[15:8];
      4'd2:    byte_atual = temp_int_asc[7:0];
      4'd3:    byte_atual = 8'h2E;
      4'd4:    byte_atual = temp_dec_asc;
      4'd5:    byte_atual = 8'h20;
      4'd6:    byte_atual = 8'h55;
      4'd7:    byte_atual = umid_int_asc[15:8];
      4'd8:    byte_atual = umid_int_asc[7:0];
      4'd9:    byte_atual = 8'h2E;
      4'd10:   byte_atual = umid_dec_asc;
      4'd11:   byte_atual = 8'h0D;
      default: byte_atual = 8'h0A;
    endcase
  end

  // Last cycle of the stop bit; lets the FSM leave ESPERA on the same edge
  assign ser_fim = ativo_q && (bit_q == 4'd9) && (baud_q == BAUD_LAST);

  // Main FSM next-state and datapath control
  always_comb begin
    estado_d  = estado_q;
    idx_d     = idx_q;
    temp_d    = temp_q;
    umid_d    = umid_q;
    ser_start = 1'b0;
    case (estado_q)
      OCIOSO:  if (transmite) estado_d = CARREGA;
      CARREGA: begin
        temp_d   = temperatura;
        umid_d   = umidade;
        idx_d    = 4'd0;
        estado_d = ENVIA;
      end
      ENVIA: begin
        ser_start = 1'b1;
        estado_d  = ESPERA;
      end
      ESPERA:  if (ser_fim) estado_d = (idx_q == 4'd12) ? FIM : PROXIMO;
      PROXIMO: begin
        idx_d    = idx_q + 4'd1;
        estado_d = ENVIA;
      end
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  // Serializer: start bit, 8 data bits LSB first, stop bit, each BAUD_DIV cycles
  always_comb begin
    ativo_d = ativo_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    if (ser_start) begin
      ativo_d = 1'b1;
      baud_d  = '0;
      bit_d   = 4'd0;
      sh_d    = byte_atual;
      tx_d    = 1'b0;
    end else if (ativo_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          ativo_d = 1'b0;
          bit_d   = 4'd0;
          tx_d    = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd8) begin
            tx_d = 1'b1;
          end else begin
            tx_d = sh_q[0];
            sh_d = {1'b0, sh_q[7:1]};
          end
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
  end

  // State registers; reset drops the frame and returns the line high at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      idx_q    <= 4'd0;
      temp_q   <= 16'h0;
      umid_q   <= 16'h0;
      ativo_q  <= 1'b0;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      sh_q     <= 8'h0;
      tx_q     <= 1'b1;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      temp_q   <= temp_d;
      umid_q   <= umid_d;
      ativo_q  <= ativo_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
    end
  end

  assign tx_serial = tx_q;
  assign ocupado   = (estado_q != OCIOSO);
  assign pronto    = (estado_q == FIM);
  assign db_estado = estado_q;

endmodule
